fp32_to_fp16_cvt: RTL
=====================

Name: fp32_to_fp16_cvt

Overview:
- Downstream stage of the FP32 add/mul IPs in the mixed-precision datapath.
- Consumes FP32 results and narrows them to IEEE 754 binary16 for storage in the FP16 register file.
- Rounding is round-to-nearest-even (RNE). Each result carries per-result exception flags; the block also keeps sticky flags for software readback.
- Fully pipelined: 2-cycle latency, 1 result per cycle, no backpressure (matches the upstream valid-only protocol).

Parameters:
- none (latency fixed at 2; formats fixed FP32 in, FP16 out)

Ports:
- aclk  input  1  clock, rising edge
- areset  input  1  asynchronous reset, active-high
- s_axis_a_tvalid  input  1  input sample valid
- s_axis_a_tdata  input  32  FP32 operand
- flags_clear  input  1  synchronous clear of sticky flags
- m_axis_result_tvalid  output  1  result valid
- m_axis_result_tdata  output  16  FP16 result
- m_axis_result_tuser  output  4  per-result flags {invalid, overflow, underflow, inexact}
- sticky_flags  output  4  OR-accumulated flags, same bit order

Behaviour:
- Interface: one clock (aclk); asynchronous active-high reset (areset).
- Reset:
  - areset=1 clears both pipeline valid bits.
  - All outputs go to 0: tvalid, tdata, tuser, sticky_flags.
  - Mid-operation reset discards in-flight samples; none emerges after release.
- Latency:
  - Sample accepted at rising edge k (tvalid=1) appears with m_axis_result_tvalid=1 after edge k+2.
  - Back-to-back inputs give back-to-back outputs.
  - Bubbles propagate unchanged.
- Data hold: when m_axis_result_tvalid=0, tdata/tuser hold their last values.
- Stage 1 (unpack):
  - Split sign s, exponent E (8b), mantissa M (23b).
  - Compute e = E-112 as signed 10b.
  - Classify: NaN, Inf, zero/FP32-subnormal, normal-range, overflow, FP16-subnormal.
  - Form the 10b candidate mantissa plus guard and sticky bits.
- Stage 2 (round/pack):
  - Apply RNE: increment if guard & (sticky | lsb).
  - A mantissa carry increments the exponent.
  - Pack the result and generate flags.
- Conversion rules:
  - NaN (E=255, M≠0): output {s,5'h1F,1'b1,M[21:13]}. invalid=1 if signaling (M[22]=0). No other flags.
  - Inf (E=255, M=0): output {s,15'h7C00}. No flags.
  - E=0 (zero or FP32 subnormal): output {s,15'h0000}. If M≠0 then underflow=1 and inexact=1.
  - 1≤e≤30: mant=M[22:13], guard=M[12], sticky=|M[11:0].
    - If rounding carries into e=31: output {s,7C00}, overflow=1, inexact=1.
  - e≥31: output {s,7C00}, overflow=1, inexact=1.
  - e≤0, subnormal path:
    - Shift {1,M} right by (1-e) into the 10b field, collecting guard/sticky.
    - If 1-e ≥ 12, the result is ±0 with guard/sticky derived from the entire significand.
    - Rounding up to 0x0400 (min normal) is a legal result.
    - underflow=1 iff the result is tiny (pre-round e≤0) and inexact.
  - inexact=1 whenever guard|sticky=1 on finite inputs.
- Sticky flags:
  - Each cycle: sticky <= (flags_clear ? 0 : sticky) | (m_tvalid_next ? tuser_next : 0).
  - Clear and a simultaneous new event: the new event is recorded (set wins).

Test Plan:
- 0x3F800000 (1.0) → 0x3C00, tuser=0. 0x477FE000 (65504) → 0x7BFF, tuser=0. Results arrive exactly 2 cycles after input.
- RNE ties: 0x3F801000 → 0x3C00 with inexact. 0x3F803000 → 0x3C02 with inexact. 0x477FF000 (65520) → 0x7C00 with overflow+inexact.
- Subnormals:
  - 0x33800000 (2^-24) → 0x0001, tuser=0.
  - 0x33000000 (2^-25) → 0x0000 with underflow+inexact.
  - 0xB3C00000 (-1.5·2^-24) → 0x8002 with underflow+inexact.
  - 0x00000001 → 0x0000 with underflow+inexact.
- Specials: 0x7F800001 → 0x7E00 with invalid. 0x7FC00000 → 0x7E00, tuser=0. 0xFF800000 → 0xFC00. 0x80000000 → 0x8000.
- Streaming/reset:
  - 8 back-to-back samples with a 1-cycle bubble → 8 results in order, with the bubble preserved.
  - Assert areset while 2 samples are in flight → tvalid=0 immediately; no results after release; sticky=0.
- Sticky: overflow sample, then flags_clear=1 on the same cycle as an inexact result emerges → sticky=4'b0001 afterwards.

Source files
------------

// File: rtl/fp32_to_fp16_cvt.sv
// FP32 -> FP16 (binary16) narrowing converter with round-to-nearest-even.
// Three register ranks: input capture, unpack/classify, round/pack.
// A sample captured at edge k leaves the output register after edge k+2.
// Per-result flags are {invalid, overflow, underflow, inexact}.
// Sticky flags OR-accumulate these flags and can be cleared by software.
module fp32_to_fp16_cvt (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_axis_a_tvalid,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        flags_clear,
    output logic        m_axis_result_tvalid,
    output logic [15:0] m_axis_result_tdata,
    output logic [3:0]  m_axis_result_tuser,
    output logic [3:0]  sticky_flags
);

    typedef enum logic [2:0] {
        CLS_NAN,
        CLS_INF,
        CLS_ZERO,
        CLS_OVF,
        CLS_NORM,
        CLS_SUB
    } cls_t;

    // Input capture rank
    logic        in_valid;
    logic [31:0] in_data;

    // Unpack (stage 1) combinational results
    logic              sign_c;
    logic [7:0]        exp_in;
    logic [22:0]       man_in;
    logic signed [9:0] e_c;
    logic [23:0]       sig;
    logic [3:0]        sub_shm1;
    logic [35:0]       sub_wide;
    cls_t              cls_c;
    logic [4:0]        exp5_c;
    logic [9:0]        mant_c;
    logic              guard_c;
    logic              sticky_c;
    logic              snan_c;

    // Stage 1 registers
    logic        s1_valid;
    logic        s1_sign;
    cls_t        s1_cls;
    logic [4:0]  s1_exp;
    logic [9:0]  s1_mant;
    logic        s1_guard;
    logic        s1_sticky;
    logic        s1_snan;

    // Round/pack (stage 2) combinational results
    logic        round_up;
    logic        inexact;
    logic [14:0] rounded;
    logic [15:0] res_data;
    logic [3:0]  res_flags;

    // Register the incoming sample; data only moves on a valid beat.
    always_ff @(posedge aclk or posedge areset) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge value of its sources, independent of block order.
        if (areset) begin
            in_valid <= 1'b0;
            in_data  <= '0;
        end else begin
            in_valid <= s_axis_a_tvalid;
            if (s_axis_a_tvalid) begin
                in_data <= s_axis_a_tdata;
            end
        end
    end

    // Unpack: classify the operand and form mantissa, guard and sticky.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        sign_c   = in_data[31];
        exp_in   = in_data[30:23];
        man_in   = in_data[22:0];
        e_c      = $signed({2'b00, exp_in}) - 10'sd112;
        sig      = {1'b1, man_in};

        // Subnormal alignment: shift by (1-e). Beyond 12 every significand
        // bit lands in sticky, so the amount is clamped there. The field is
        // pre-shifted by one place, hence the (shift-1) encoding.
        if (e_c <= -10'sd11) begin
            sub_shm1 = 4'd11;
        end else begin
            sub_shm1 = 4'(-e_c);
        end
        sub_wide = {sig, 12'b0} >> sub_shm1;

        cls_c    = CLS_NORM;
        exp5_c   = e_c[4:0];
        mant_c   = man_in[22:13];
        guard_c  = man_in[12];
        sticky_c = |man_in[11:0];
        snan_c   = 1'b0;

        if (exp_in == 8'hFF) begin
            exp5_c   = 5'h1F;
            mant_c   = {1'b1, man_in[21:13]};
            guard_c  = 1'b0;
            sticky_c = 1'b0;
            if (man_in != 23'd0) begin
                cls_c  = CLS_NAN;
                snan_c = ~man_in[22];
            end else begin
                cls_c  = CLS_INF;
            end
        end else if (exp_in == 8'h00) begin
            // Zero and FP32 subnormals flush to signed zero; sticky marks
            // a nonzero operand so stage 2 can raise underflow/inexact.
            cls_c    = CLS_ZERO;
            exp5_c   = 5'd0;
            mant_c   = 10'd0;
            guard_c  = 1'b0;
            sticky_c = |man_in;
        end else if (e_c >= 10'sd31) begin
            cls_c    = CLS_OVF;
            exp5_c   = 5'h1F;
            mant_c   = 10'd0;
            guard_c  = 1'b0;
            sticky_c = 1'b0;
        end else if (e_c <= 10'sd0) begin
            cls_c    = CLS_SUB;
            exp5_c   = 5'd0;
            mant_c   = sub_wide[35:26];
            guard_c  = sub_wide[25];
            sticky_c = |sub_wide[24:0];
        end
    end

    // Stage 1 register: classified operand and rounding inputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_cls    <= CLS_ZERO;
            s1_exp    <= '0;
            s1_mant   <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_snan   <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign   <= sign_c;
                s1_cls    <= cls_c;
                s1_exp    <= exp5_c;
                s1_mant   <= mant_c;
                s1_guard  <= guard_c;
                s1_sticky <= sticky_c;
                s1_snan   <= snan_c;
            end
        end
    end

    // Round/pack: RNE increment on {exp, mant}, so a mantissa carry bumps
    // the exponent (subnormal 0x3FF rounds up to min normal 0x400).
    always_comb begin
        round_up  = s1_guard & (s1_sticky | s1_mant[0]);
        inexact   = s1_guard | s1_sticky;
        rounded   = {s1_exp, s1_mant} + {14'd0, round_up};
        res_data  = {s1_sign, rounded};
        res_flags = 4'b0000;

        case (s1_cls)
            CLS_NAN: begin
                res_data  = {s1_sign, 5'h1F, s1_mant};
                res_flags = {s1_snan, 3'b000};
            end
            CLS_INF: begin
                res_data  = {s1_sign, 15'h7C00};
                res_flags = 4'b0000;
            end
            CLS_ZERO: begin
                res_data  = {s1_sign, 15'h0000};
                res_flags = {2'b00, s1_sticky, s1_sticky};
            end
            CLS_OVF: begin
                res_data  = {s1_sign, 15'h7C00};
                res_flags = 4'b0101;
            end
            CLS_NORM: begin
                // Rounding from 0x7BFF lands exactly on the infinity code.
                res_data  = {s1_sign, rounded};
                res_flags = {1'b0, (rounded[14:10] == 5'h1F), 1'b0, inexact};
            end
            CLS_SUB: begin
                res_data  = {s1_sign, rounded};
                res_flags = {2'b00, inexact, inexact};
            end
            default: begin
                res_data  = {s1_sign, rounded};
                res_flags = 4'b0000;
            end
        endcase
    end

    // Output register: data/flags hold while no result is valid.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_result_tvalid <= 1'b0;
            m_axis_result_tdata  <= '0;
            m_axis_result_tuser  <= '0;
        end else begin
            m_axis_result_tvalid <= s1_valid;
            if (s1_valid) begin
                m_axis_result_tdata <= res_data;
                m_axis_result_tuser <= res_flags;
            end
        end
    end

    // Sticky flags: clear first, then OR in the emerging result (set wins).
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sticky_flags <= '0;
        end else begin
            sticky_flags <= (flags_clear ? 4'b0000 : sticky_flags)
                          | (s1_valid ? res_flags : 4'b0000);
        end
    end

endmodule
